byte_link_rx: RTL and testbench

BYTE_LINK_RX -- requirements
Module: byte_link_rx

---
 rtl/byte_link_pkg.sv | 13 +
 rtl/byte_link_rx_fifo.sv | 51 +++++
 rtl/byte_link_rx.sv | 82 ++++++++
 tb/tb_byte_link_rx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/byte_link_pkg.sv
// Shared definitions for the byte link (transmit and receive ends).
package byte_link_pkg;

    localparam int DATA_W    = 8;
    localparam int DEF_DEPTH = 4;

    typedef logic [DATA_W-1:0] byte_t;

    function automatic logic even_parity(input byte_t b);
        return ^b;
    endfunction

endpackage

// File: rtl/byte_link_rx_fifo.sv
// Show-ahead byte FIFO: storage, wrapping pointers and occupancy count.
module byte_link_rx_fifo
    import byte_link_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  byte_t         wr_data,
    output byte_t         rd_data,
    output logic [LW-1:0] count
);

    byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // NOTE: the storage is reset too, so the head byte reads 8'h00 straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to the same edge.
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/byte_link_rx.sv
// Byte link receiver: push/pop qualification, sticky error flags, FIFO.
// Optional parity checking is enabled with `define BYTE_LINK_RX_PARITY_EN.
module byte_link_rx
    import byte_link_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        d_in,
    input  logic                     d_in_vld,
`ifdef BYTE_LINK_RX_PARITY_EN
    input  logic                     d_in_par,
    output logic                     par_err,
`endif
    output logic [DATA_W-1:0]        d_out,
    output logic                     d_out_vld,
    input  logic                     d_out_rdy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     err_clr
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic par_ok;
    logic strobe_ok;
    logic full;
    logic push;
    logic pop;
    logic ovf_set;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        par_ok = 1'b1;
`ifdef BYTE_LINK_RX_PARITY_EN
        par_ok = (d_in_par == even_parity(d_in));
`endif
        strobe_ok = d_in_vld && par_ok;
        full      = (level == LW'(DEPTH));
        pop       = d_out_vld && d_out_rdy;
        // A full FIFO still accepts a byte when the head leaves in the same cycle.
        push      = strobe_ok && (!full || pop);
        ovf_set   = strobe_ok && full && !pop;
    end

    assign d_out_vld = (level != '0);

    byte_link_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (d_in),
        .rd_data (d_out),
        .count   (level)
    );

    // Sticky flags: a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (err_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef BYTE_LINK_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (d_in_vld && !par_ok) begin
            par_err <= 1'b1;
        end else if (err_clr) begin
            par_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_byte_link_rx.sv
// Scoreboard testbench for byte_link_rx (DEPTH=4); covers parity when
// BYTE_LINK_RX_PARITY_EN is defined.
module tb_byte_link_rx;
    import byte_link_pkg::*;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             d_in;
    logic                   d_in_vld;
    logic [7:0]             d_out;
    logic                   d_out_vld;
    logic                   d_out_rdy;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;
    logic                   err_clr;
`ifdef BYTE_LINK_RX_PARITY_EN
    logic                   d_in_par;
    logic                   par_err;
    logic                   bad_par = 1'b0;
    assign d_in_par = (^d_in) ^ bad_par;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    byte_link_rx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .d_in_vld  (d_in_vld),
`ifdef BYTE_LINK_RX_PARITY_EN
        .d_in_par  (d_in_par),
        .par_err   (par_err),
`endif
        .d_out     (d_out),
        .d_out_vld (d_out_vld),
        .d_out_rdy (d_out_rdy),
        .level     (level),
        .ovf       (ovf),
        .err_clr   (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the handshake that the
    // next edge will see is sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && d_out_vld && d_out_rdy) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("sb_data", d_out, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit expect_kept);
        d_in     = b;
        d_in_vld = 1'b1;
        if (expect_kept) exp_q.push_back(b);
        step();
        d_in_vld = 1'b0;
    endtask

    task automatic drain();
        d_out_rdy = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (!d_out_vld) break;
            step();
        end
        d_out_rdy = 1'b0;
        check("drain_done", d_out_vld, 0);
        check("drain_level", level, 0);
        check("drain_sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; d_in = '0; d_in_vld = 1'b0; d_out_rdy = 1'b0; err_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_level", level, 0);
        check("rst_vld", d_out_vld, 0);
        check("rst_ovf", ovf, 0);
        check("rst_dout", d_out, 8'h00);

        // Single byte, latency 1
        send(8'hA5, 1);
        check("single_vld", d_out_vld, 1);
        check("single_dout", d_out, 8'hA5);
        check("single_level", level, 1);
        d_out_rdy = 1'b1;
        step();
        d_out_rdy = 1'b0;
        check("single_pop_level", level, 0);
        check("single_pop_vld", d_out_vld, 0);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) send(8'(i), i <= DEPTH);
        check("fill_level", level, DEPTH);
        check("fill_ovf", ovf, 1);
        drain();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovf_cleared", ovf, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) send(8'h21 + 8'(i), 1);
        check("full_level", level, DEPTH);
        d_out_rdy = 1'b1;
        send(8'h55, 1);
        d_out_rdy = 1'b0;
        check("full_pp_level", level, DEPTH);
        check("full_pp_ovf", ovf, 0);
        drain();

        // Streaming across pointer wrap
        d_out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(8'h10 + 8'(i), 1);
            check("wrap_level_le1", 32'(level <= 1), 1);
        end
        drain();

        // Overflow coinciding with err_clr
        for (int i = 0; i < DEPTH; i++) send(8'h30 + 8'(i), 1);
        send(8'h3F, 0);
        check("flag_ovf_set", ovf, 1);
        err_clr = 1'b1;
        send(8'h3E, 0);
        check("flag_set_wins", ovf, 1);
        step();
        err_clr = 1'b0;
        check("flag_clr", ovf, 0);
        drain();

        // Reset mid-stream
        for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), 1);
        check("mid_level", level, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_level", level, 0);
        check("mid_rst_vld", d_out_vld, 0);
        check("mid_rst_dout", d_out, 8'h00);

`ifdef BYTE_LINK_RX_PARITY_EN
        bad_par = 1'b1;
        send(8'h03, 0);
        bad_par = 1'b0;
        check("par_err_set", par_err, 1);
        check("par_drop_level", level, 0);
        send(8'h03, 1);
        check("par_good_level", level, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("par_err_clr", par_err, 0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
